// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared definitions for the UART receive path and its consumer.
//            - deframer state encoding
//            - default clocks-per-bit (50 MHz / 115200 baud)
//            - system-control opcodes carried over the command link
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  localparam int c_default_clks_per_bit = 434;

  localparam logic [7:0] c_op_halt   = 8'h00;
  localparam logic [7:0] c_op_resume = 8'h01;
  localparam logic [7:0] c_op_write  = 8'h02;
  localparam logic [7:0] c_op_read   = 8'h03;
  localparam logic [7:0] c_op_reset  = 8'h04;
  localparam logic [7:0] c_op_ping   = 8'h05;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock first-word-fall-through byte FIFO.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            push, push_data   - write request and data
//            pop               - read request (ignored while empty)
//            head              - oldest entry, 0 while empty
//            count             - fill level, 0..FIFO_DEPTH
//            full, empty       - status
// Notes    : A push while full is accepted only if a pop happens in the
//            same cycle; otherwise it is dropped (the caller flags it).
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [DATA_W-1:0]           push_data,
  input  logic                        pop,
  output logic [DATA_W-1:0]           head,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        full,
  output logic                        empty
);

  localparam int c_aw = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [c_aw:0]     r_wr_ptr;
  logic [c_aw:0]     r_rd_ptr;
  logic              w_do_pop;
  logic              w_do_push;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]) &&
                 (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]);

  assign w_do_pop  = pop && !empty;
  // When full, the slot being written is the one being popped this cycle.
  assign w_do_push = push && (!full || w_do_pop);

  assign count = r_wr_ptr - r_rd_ptr;
  assign head  = empty ? '0 : r_mem[r_rd_ptr[c_aw-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: contents are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : 8N1 UART receiver (2-flop synchronizer + oversampling deframer)
//            feeding a byte FIFO drained through a valid/ready handshake.
// Ports    : clk, rst    - clock, synchronous active-high reset
//            uart_rx     - asynchronous serial line, idle high
//            rx_ready    - consumer takes the head byte this cycle
//            clr_status  - clears the sticky overrun flag
//            rx_valid    - FIFO non-empty
//            rx_data     - head byte (first-word-fall-through), 0 when empty
//            fifo_count  - FIFO fill level
//            rx_busy     - deframer is mid-frame
//            overrun     - sticky: a byte was dropped on a full FIFO
//            frame_err   - one-cycle pulse on a bad stop bit
// Config   : UART_RX_FRAMING_CHECK_EN - when defined, bytes with a low stop
//            bit are discarded and flagged on frame_err; otherwise they are
//            stored and frame_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = c_default_clks_per_bit,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        uart_rx,
  input  logic                        rx_ready,
  input  logic                        clr_status,
  output logic                        rx_valid,
  output logic [7:0]                  rx_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        rx_busy,
  output logic                        overrun,
  output logic                        frame_err
);

  localparam int              c_cw   = $clog2(CLKS_PER_BIT);
  localparam logic [c_cw-1:0] c_half = c_cw'(CLKS_PER_BIT / 2);
  localparam logic [c_cw-1:0] c_last = c_cw'(CLKS_PER_BIT - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_prev;

  rx_state_t       r_state;
  rx_state_t       w_state_nxt;
  logic [c_cw-1:0] r_cnt;
  logic [c_cw-1:0] w_cnt_nxt;
  logic [2:0]      r_bit_idx;
  logic [2:0]      w_bit_idx_nxt;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_nxt;
  logic            w_push;

  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic            w_pop;
  logic            w_ovr_evt;
  logic            r_overrun;

`ifdef UART_RX_FRAMING_CHECK_EN
  logic            w_frame_err_nxt;
  logic            r_frame_err;
`endif

  // --------------------------------------------------------------------------
  // Synchronizer; r_prev holds the previous synchronized sample for edge
  // detection. All three reset high so reset never looks like a start edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // --------------------------------------------------------------------------
  // Deframer state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Deframer next state. Edge detection needs a 1->0 transition, so a line
  // held low (break) cannot start a new frame until it has gone high again.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_push        = 1'b0;
`ifdef UART_RX_FRAMING_CHECK_EN
    w_frame_err_nxt = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (r_prev && !r_sync2) w_state_nxt = ST_START;
      end
      ST_START: begin
        if (r_cnt == c_half) begin
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = '0;
          // Line already back high at mid start bit: a glitch, not a frame.
          w_state_nxt   = r_sync2 ? ST_IDLE : ST_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (r_cnt == c_last) begin
          w_cnt_nxt     = '0;
          w_shift_nxt   = {r_sync2, r_shift[7:1]};  // LSB arrives first
          w_bit_idx_nxt = r_bit_idx + 1'b1;
          if (r_bit_idx == 3'd7) w_state_nxt = ST_STOP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (r_cnt == c_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
`ifdef UART_RX_FRAMING_CHECK_EN
          w_push          = r_sync2;
          w_frame_err_nxt = !r_sync2;
`else
          w_push          = 1'b1;
`endif
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign rx_busy = (r_state != ST_IDLE);

  // --------------------------------------------------------------------------
  // FIFO and handshake
  // --------------------------------------------------------------------------
  assign rx_valid  = !w_fifo_empty;
  assign w_pop     = rx_valid && rx_ready;
  assign w_ovr_evt = w_push && w_fifo_full && !w_pop;

  sync_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (r_shift),
    .pop       (w_pop),
    .head      (rx_data),
    .count     (fifo_count),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  // Sticky overrun; a new drop in the clearing cycle keeps it set.
  always_ff @(posedge clk) begin
    if (rst)             r_overrun <= 1'b0;
    else if (w_ovr_evt)  r_overrun <= 1'b1;
    else if (clr_status) r_overrun <= 1'b0;
  end

  assign overrun = r_overrun;

`ifdef UART_RX_FRAMING_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) r_frame_err <= 1'b0;
    else     r_frame_err <= w_frame_err_nxt;
  end

  assign frame_err = r_frame_err;
`else
  assign frame_err = 1'b0;
`endif

endmodule
`default_nettype wire
